miner: RTL and testbench

//  Bitcoin block-header hasher: serialises an 80-byte header from its fields and computes SHA256(SHA256(header)).
//  One multi-cycle job per start pulse; iterative, one SHA-256 round per clock.

---
 rtl/miner_pkg.sv | 53 +++++
 rtl/miner_sha256_core.sv | 50 +++++
 rtl/miner.sv | 95 +++++++++
 tb/tb_miner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: SHA-256 round constants, initial hash, FSM state type and bit helpers shared by the miner.
package miner_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction
endpackage

// File: rtl/miner_sha256_core.sv
// sha256_core: iterative SHA-256 compression, one round per clock.
// valid (with h_out = h_in + working vars) is high in the 65th cycle after load; load may coincide with valid.
module sha256_core
  import miner_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [511:0] block,
  input  logic [255:0] h_in,
  output logic [255:0] h_out,
  output logic         valid
);
  state_e st_q, st_d;
  logic [5:0] cnt_q, cnt_d;
  logic [511:0] w_q, w_d;
  logic [255:0] h_q, h_d, v_q, v_d;
  logic [31:0] a, b, c, d, e, f, g, h, t1, t2, w_new;

  always_comb begin
    {a, b, c, d, e, f, g, h} = v_q;
    t1 = h + bsig1(e) + ch(e, f, g) + K[cnt_q] + w_q[511:480];
    t2 = bsig0(a) + maj(a, b, c);
    // w_q holds W[t..t+15], W[t] in the top word; the ring shifts left each round
    w_new = ssig1(w_q[63:32]) + w_q[223:192] + ssig0(w_q[479:448]) + w_q[511:480];
    h_out = '0;
    for (int i = 0; i < 8; i++) h_out[255-32*i -: 32] = h_q[255-32*i -: 32] + v_q[255-32*i -: 32];
    valid = st_q == ADD;
    st_d = load ? ROUND : st_q == ROUND ? (cnt_q == 6'd63 ? ADD : ROUND) : IDLE;
    cnt_d = load ? 6'd0 : st_q == ROUND ? cnt_q + 6'd1 : cnt_q;
    w_d = load ? block : st_q == ROUND ? {w_q[479:0], w_new} : w_q;
    v_d = load ? h_in : st_q == ROUND ? {t1 + t2, a, b, c, d + t1, e, f, g} : v_q;
    h_d = load ? h_in : h_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q <= IDLE;
      cnt_q <= '0;
      w_q <= '0;
      h_q <= '0;
      v_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      w_q <= w_d;
      h_q <= h_d;
      v_q <= v_d;
    end
endmodule

// File: rtl/miner.sv
// miner: Bitcoin header double-SHA-256 over three chained compressions (195 cycles per job).
// MINER_MIDSTATE_EN caches the block-1 midstate so a repeated 64-byte header prefix skips block 1 (130 cycles).
module miner
  import miner_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         done,
  input  logic [31:0]  version,
  input  logic [255:0] hashPrevBlock,
  input  logic [255:0] hashMerkleRoot,
  input  logic [31:0]  timestamp,
  input  logic [31:0]  bits,
  input  logic [31:0]  nonce,
  output logic [255:0] hash_out
);
  state_e st_q, st_d;
  logic [1:0] blk_q, blk_d;
  logic [639:0] hdr_q, hdr_d, hdr_in, src;
  logic [255:0] hash_q, hash_d, c_hin, c_hout, mid;
  logic [511:0] c_blk;
  logic done_q, done_d, accept, hit, c_load, c_valid;
`ifdef MINER_MIDSTATE_EN
  logic mval_q, mval_d;
  logic [511:0] mblk_q, mblk_d;
  logic [255:0] mid_q, mid_d;
`endif

  always_comb begin
    hdr_in = {bswap32(version), bswap256(hashPrevBlock), bswap256(hashMerkleRoot),
              bswap32(timestamp), bswap32(bits), bswap32(nonce)};
    accept = start && (st_q == IDLE || st_q == DONE);
    src = accept ? hdr_in : hdr_q;
`ifdef MINER_MIDSTATE_EN
    hit = mval_q && mblk_q == hdr_in[639:128];
    mid = mid_q;
    mval_d = mval_q || (c_valid && blk_q == 2'd0);
    mblk_d = c_valid && blk_q == 2'd0 ? src[639:128] : mblk_q;
    mid_d = c_valid && blk_q == 2'd0 ? c_hout : mid_q;
`else
    hit = 1'b0;
    mid = '0;
`endif
    // blk_q names the block in flight: 0/1 = pass-1 blocks, 2 = pass-2 block
    c_load = accept || (c_valid && blk_q != 2'd2);
    c_blk = accept && !hit ? src[639:128]
          : accept || blk_q == 2'd0 ? {src[127:0], 8'h80, 312'd0, 64'd640}
          : {c_hout, 8'h80, 184'd0, 64'd256};
    c_hin = accept ? (hit ? mid : H0) : blk_q == 2'd0 ? c_hout : H0;
    blk_d = accept ? {1'b0, hit} : c_valid ? blk_q + 2'd1 : blk_q;
    st_d = accept ? ROUND : c_valid && blk_q == 2'd2 ? DONE : st_q;
    done_d = accept ? 1'b0 : c_valid && blk_q == 2'd2 ? 1'b1 : done_q;
    hash_d = c_valid && blk_q == 2'd2 ? bswap256(c_hout) : hash_q;
    hdr_d = src;
  end

  sha256_core u_core (
    .clk(clk),
    .reset(reset),
    .load(c_load),
    .block(c_blk),
    .h_in(c_hin),
    .h_out(c_hout),
    .valid(c_valid)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q <= IDLE;
      blk_q <= '0;
      hdr_q <= '0;
      hash_q <= '0;
      done_q <= 1'b0;
`ifdef MINER_MIDSTATE_EN
      mval_q <= 1'b0;
      mblk_q <= '0;
      mid_q <= '0;
`endif
    end else begin
      st_q <= st_d;
      blk_q <= blk_d;
      hdr_q <= hdr_d;
      hash_q <= hash_d;
      done_q <= done_d;
`ifdef MINER_MIDSTATE_EN
      mval_q <= mval_d;
      mblk_q <= mblk_d;
      mid_q <= mid_d;
`endif
    end

  assign done = done_q;
  assign hash_out = hash_q;
endmodule

// File: tb/tb_miner.sv
// tb_miner: directed checks of miner against known Bitcoin block hashes and a reference double-SHA-256 model.
module tb_miner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic done;
  logic [31:0] version, timestamp, bits, nonce;
  logic [255:0] prev, merkle, hash_out;
  int n_chk = 0;
  int n_fail = 0;
  int lat;

  localparam logic [255:0] P125 = 256'h00000000000008a3a41b85b8b29ad444def299fee21793cd8b9e567eab02cd81;
  localparam logic [255:0] M125 = 256'h2b12fcf1b09288fcaff797d71e950e71ae42b91e8bdb2304758dfcffc2b620e3;
  localparam logic [255:0] R125 = 256'h00000000000000001e8d6829a8a21adc5d38d0a473b144b6765798e61f98bd1d;
  localparam logic [255:0] MGEN = 256'h4a5e1e4baab89f3a32518a88c31bc87f618f76673e2cc77ab2127b7afdeda33b;
  localparam logic [255:0] RGEN = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
`ifdef MINER_MIDSTATE_EN
  localparam int LAT_REPEAT = 130;
`else
  localparam int LAT_REPEAT = 195;
`endif

  always #5 clk = ~clk;

  miner dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .done(done),
    .version(version),
    .hashPrevBlock(prev),
    .hashMerkleRoot(merkle),
    .timestamp(timestamp),
    .bits(bits),
    .nonce(nonce),
    .hash_out(hash_out)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] le(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] rev(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  function automatic logic [255:0] comp(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 64; t++)
      if (t < 16) w[t] = m[511-32*t -: 32];
      else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + miner_pkg::K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] dsha(input logic [639:0] hdr);
    logic [255:0] h;
    h = comp(IV, hdr[639:128]);
    h = comp(h, {hdr[127:0], 8'h80, 312'd0, 64'd640});
    h = comp(IV, {h, 8'h80, 184'd0, 64'd256});
    return rev(h);
  endfunction

  task automatic set125(input logic [31:0] n);
    @(negedge clk);
    version = 32'd1; prev = P125; merkle = M125;
    timestamp = 32'd1305998791; bits = 32'd440711666; nonce = n;
  endtask

  task automatic setgen();
    @(negedge clk);
    version = 32'd1; prev = '0; merkle = MGEN;
    timestamp = 32'd1231006505; bits = 32'd486604799; nonce = 32'd2083236893;
  endtask

  task automatic run(input bit meddle, output int cycles);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (!done && cycles < 400) begin
      if (meddle) begin
        if (cycles == 1) nonce = '0;
        start = cycles == 50;
      end
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  initial begin
    set125(32'd2504433986);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_hash", hash_out, 0);
    @(negedge clk) reset = 1'b1;

    run(0, lat);
    check("b125_hash", hash_out, R125);
    check("b125_lat", lat, 195);

    setgen();
    run(0, lat);
    check("gen_hash", hash_out, RGEN);
    check("gen_lat", lat, 195);

    set125(32'd2504433986);
    run(1, lat);
    check("capture_hash", hash_out, R125);
    check("capture_lat", lat, 195);

    repeat (10) @(posedge clk);
    #1;
    check("hold_done", done, 1);
    check("hold_hash", hash_out, R125);

    set125(32'd2504433986);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    check("busy_done", done, 0);
    reset = 1'b0;
    #1;
    check("abort_done", done, 0);
    check("abort_hash", hash_out, 0);
    @(negedge clk) reset = 1'b1;

    setgen();
    run(0, lat);
    check("regen_hash", hash_out, RGEN);
    check("regen_lat", lat, 195);

    set125(32'd2504433986);
    run(0, lat);
    check("b125_again", hash_out, R125);
    check("b125_again_lat", lat, 195);

    set125(32'd2504433987);
    run(0, lat);
    check("sweep_hash", hash_out, dsha({le(version), rev(prev), rev(merkle), le(timestamp), le(bits), le(nonce)}));
    check("sweep_top64", |hash_out[255:192], 1);
    check("sweep_lat", lat, LAT_REPEAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
